// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the program counter, tags fetched words with their PC,
// handles stall/branch/halt and shares the imem write port with a streaming program loader.
module instr_fetch_ctrl #(
    parameter int                      PROG_CTR_WID = 10,
    parameter logic [PROG_CTR_WID-1:0] START_ADDR   = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stall,
    input  logic                    branch_taken,
    input  logic [PROG_CTR_WID-1:0] branch_target,
    input  logic                    halt_req,
    output logic [PROG_CTR_WID-1:0] prog_ctr,
    input  logic [15:0]             imem_rdata,
    output logic                    instr_valid,
    output logic [15:0]             instr_out,
    output logic [PROG_CTR_WID-1:0] pc_out,
    input  logic                    load_req,
    input  logic                    load_valid,
    input  logic [15:0]             load_data,
    output logic                    load_ready,
    output logic                    imem_we,
    output logic [PROG_CTR_WID-1:0] imem_waddr,
    output logic [15:0]             imem_wdata,
    output logic                    load_done,
    output logic                    halted,
    output logic                    pc_wrap
);

    // state  | meaning
    // IDLE   | waiting for start or load_req
    // LOAD   | streaming program words into imem
    // RUN    | fetching one word per cycle
    // FLUSH  | first fetch after redirect/resume, output not yet valid
    // HALTED | fetch stopped, prog_ctr holds next unissued address
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_FLUSH,
        S_HALTED
    } state_t;

    state_t                  state, state_nxt;
    logic [PROG_CTR_WID-1:0] load_cnt, load_cnt_nxt;
    logic [PROG_CTR_WID-1:0] prog_ctr_nxt, pc_out_nxt, imem_waddr_nxt;
    logic [15:0]             instr_out_nxt, imem_wdata_nxt;
    logic                    instr_valid_nxt, imem_we_nxt, load_done_nxt, pc_wrap_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            load_cnt    <= '0;
            prog_ctr    <= '0;
            pc_out      <= '0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            imem_we     <= 1'b0;
            imem_waddr  <= '0;
            imem_wdata  <= '0;
            load_ready  <= 1'b0;
            load_done   <= 1'b0;
            halted      <= 1'b0;
            pc_wrap     <= 1'b0;
        end else begin
            state       <= state_nxt;
            load_cnt    <= load_cnt_nxt;
            prog_ctr    <= prog_ctr_nxt;
            pc_out      <= pc_out_nxt;
            instr_out   <= instr_out_nxt;
            instr_valid <= instr_valid_nxt;
            imem_we     <= imem_we_nxt;
            imem_waddr  <= imem_waddr_nxt;
            imem_wdata  <= imem_wdata_nxt;
            load_ready  <= (state_nxt == S_LOAD);
            load_done   <= load_done_nxt;
            halted      <= (state_nxt == S_HALTED);
            pc_wrap     <= pc_wrap_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        load_cnt_nxt    = load_cnt;
        prog_ctr_nxt    = prog_ctr;
        pc_out_nxt      = pc_out;
        instr_out_nxt   = instr_out;
        instr_valid_nxt = instr_valid;
        imem_we_nxt     = 1'b0;
        imem_waddr_nxt  = imem_waddr;
        imem_wdata_nxt  = imem_wdata;
        load_done_nxt   = 1'b0;
        pc_wrap_nxt     = 1'b0;

        case (state)
            S_IDLE: begin
                instr_valid_nxt = 1'b0;
                if (load_req) begin
                    state_nxt = S_LOAD;
                end else if (start) begin
                    state_nxt    = S_RUN;
                    prog_ctr_nxt = START_ADDR;
                end
            end
            S_LOAD: begin
                instr_valid_nxt = 1'b0;
                if (load_valid) begin
                    imem_we_nxt    = 1'b1;
                    imem_waddr_nxt = load_cnt;
                    imem_wdata_nxt = load_data;
                    load_cnt_nxt   = load_cnt + 1'b1;
                    // Filling the last address ends the load; the counter wraps to 0 by itself.
                    if (load_cnt == '1) begin
                        load_done_nxt = 1'b1;
                        state_nxt     = S_IDLE;
                    end
                end else if (!load_req) begin
                    load_done_nxt = 1'b1;
                    load_cnt_nxt  = '0;
                    state_nxt     = S_IDLE;
                end
            end
            S_RUN, S_FLUSH: begin
                // Priority: halt, then branch, then stall, then normal advance.
                if (halt_req) begin
                    state_nxt       = S_HALTED;
                    instr_valid_nxt = 1'b0;
                    if (branch_taken) begin
                        prog_ctr_nxt = branch_target;
                    end
                end else if (branch_taken) begin
                    state_nxt       = S_FLUSH;
                    instr_valid_nxt = 1'b0;
                    prog_ctr_nxt    = branch_target;
                end else if (!stall) begin
                    state_nxt       = S_RUN;
                    instr_out_nxt   = imem_rdata;
                    pc_out_nxt      = prog_ctr;
                    instr_valid_nxt = 1'b1;
                    prog_ctr_nxt    = prog_ctr + 1'b1;
                    pc_wrap_nxt     = (prog_ctr == '1);
                end
            end
            S_HALTED: begin
                instr_valid_nxt = 1'b0;
                if (load_req) begin
                    state_nxt = S_LOAD;
                end else if (start) begin
                    state_nxt = S_FLUSH;
                end
            end
            default: begin
                state_nxt       = S_IDLE;
                instr_valid_nxt = 1'b0;
            end
        endcase
    end

endmodule
